mcs4_bus_tracer: RTL and testbench
==================================

Name: mcs4_bus_tracer

Overview:
- Passive, parametrised MCS-4 bus observer for system tops that carry one or more i4001/i4002 chips.
- Runs in the sysclk domain and watches clk2, sync, the 4-bit data bus and the CM lines.
- Reconstructs each 8-phase instruction cycle (A1..X3) into one trace record: 12-bit address, 8-bit opcode, X2 data and CM flags.
- Buffers records in a FIFO that a host or logic analyser drains through a valid/ready handshake. Never drives any MCS-4 pad.

Parameters:
NUM_CMRAM, 4, number of CM-RAM lines observed (1..8)
DEPTH, 16, FIFO depth in records (power of 2, >= 2)
OVF_WIDTH, 8, width of the saturating overflow counter
TS_WIDTH, 16, timestamp width (used only with MCS4_TRACE_TSTAMP_EN)

Ports:
sysclk  input  1  system clock; all logic rises on it
poc_n  input  1  asynchronous active-low reset
clk2  input  1  phase-2 clock as generated from sysclk (same domain, no synchroniser)
sync  input  1  bus sync, active-high during X3
data  input  4  data bus value
cmrom  input  1  CM-ROM, active-high
cmram  input  NUM_CMRAM  CM-RAM lines, active-high
trace_valid  output  1  head record available
trace_ready  input  1  consumer accepts head record
trace_data  output  RW  record; RW = 25+NUM_CMRAM (+TS_WIDTH with the optional feature)
trace_count  output  log2(DEPTH)+1  records currently held
locked  output  1  phase tracker synchronised to the bus
sync_err  output  1  sticky; a sync anomaly occurred since reset
ovf_cnt  output  OVF_WIDTH  records dropped because the FIFO was full, saturating

Behaviour:
- Reset (poc_n=0, async):
  - All outputs 0; FIFO empty; phase=0; locked=0.
  - Takes effect mid-cycle or mid-transfer; any partial record is discarded.
- Phase strobe: asserted in the sysclk cycle where clk2_q==1 and clk2==0 (clk2 falling edge; clk2_q is clk2 registered). All bus inputs are sampled only on a strobe.
- Phase tracker, 3-bit, values A1=0 .. X3=7. On each strobe:
  - sync=1 and locked=0: phase<=7, locked<=1, no record emitted. The next strobe is A1.
  - sync=1, locked=1, phase!=6: sync_err<=1; phase<=7; the in-progress record is discarded.
  - locked=1, phase==6, sync=0: sync_err<=1; locked<=0; record discarded.
  - Otherwise phase<=phase+1 (mod 8).
- Capture, when locked, on the strobe of the named phase:
  - A1 -> addr[3:0]; A2 -> addr[7:4]; A3 -> addr[11:8].
  - M1 -> op[7:4]; M2 -> op[3:0].
  - X2 -> xdata, cmrom, cmram.
- Record format, MSB first: {[ts], addr[11:0], op[7:0], xdata[3:0], cmrom, cmram[NUM_CMRAM-1:0]}.
- Push: on the X3 strobe with a valid sync, and only if all seven earlier phases were captured since lock. The first partial cycle after lock is never pushed.
- FIFO:
  - Circular, DEPTH entries; pointers one bit wider than the address.
  - trace_valid = (count != 0). trace_data is the head entry and holds stable while trace_valid=1 and trace_ready=0.
  - Pop when trace_valid && trace_ready.
  - Push while full is accepted only if a pop occurs in the same cycle. Otherwise the new record is dropped and ovf_cnt increments, saturating at all-ones.
  - Simultaneous push and pop when non-full: count unchanged.
  - Wrap-around of the pointers is transparent to the consumer.
- Latency: a record becomes visible on trace_valid one sysclk after the X3 strobe.

Optional Feature:
- Macro: MCS4_TRACE_TSTAMP_EN.
- Defined:
  - A TS_WIDTH instruction-cycle counter increments on every valid X3, including dropped records, and wraps to 0.
  - Its pre-increment value is prepended as the record MSBs. RW grows by TS_WIDTH.
  - The counter resets to 0 and does not count while unlocked.
- Undefined: no counter exists and RW = 25+NUM_CMRAM.

Test Plan:
- Reset: hold poc_n=0 with bus toggling -> all outputs 0, trace_valid=0, locked=0.
- Clean cycle, NUM_CMRAM=4:
  - Stimulus: one sync to lock, then A1..A3=3,2,1, M1=D, M2=5, X2 data=5, cmrom=1, cmram=0, sync on X3.
  - Response: one record 0x123_D5_5_1_0; trace_valid rises one sysclk after the X3 strobe.
- Overflow, DEPTH=4, trace_ready=0:
  - Stimulus: 6 clean cycles, then trace_ready=1 and drain.
  - Response: ovf_cnt=2, trace_count=4, drained records are the first 4 in order.
- Full-with-pop: FIFO full with trace_ready=1 in the X3 cycle -> push accepted, count stays 4, ovf_cnt unchanged.
- Sync error:
  - Stimulus: sync asserted at M2 while locked.
  - Response: sync_err=1, the partial record is discarded, and the next full cycle is recorded normally.
- Reset mid-cycle: poc_n pulsed low at M1 -> FIFO empty, locked=0; the first record appears only after a fresh sync and a full A1..X3 cycle.
- Timestamp (with MCS4_TRACE_TSTAMP_EN): 3 clean cycles -> ts fields 0, 1, 2.

Source files
------------

// File: rtl/mcs4_bus_tracer_if.sv
// Bundle of the observed MCS-4 bus lines plus the trace drain port of
// mcs4_bus_tracer. The slave modport is the tracer; the master modport is the
// system/host side that owns the bus and consumes records.
//
// Trace handshake: trace_valid is high whenever the FIFO holds a record and
// trace_data is then the head record; it stays stable while trace_valid=1 and
// trace_ready=0. A record is consumed on every sysclk rising edge where
// trace_valid && trace_ready are both high; the consumer may hold trace_ready
// high permanently.
//
// Optional feature macro: MCS4_TRACE_TSTAMP_EN (prepends a timestamp).
interface mcs4_bus_tracer_if #(
  parameter int NUM_CMRAM = 4,
  parameter int DEPTH     = 16,
  parameter int OVF_WIDTH = 8,
  parameter int TS_WIDTH  = 16
);
`ifdef MCS4_TRACE_TSTAMP_EN
  localparam int TS_EN = 1;
`else
  localparam int TS_EN = 0;
`endif
  localparam int RW = 25 + NUM_CMRAM + TS_EN * TS_WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;

  // observed MCS-4 bus lines
  logic                  clk2;
  logic                  sync;
  logic [3:0]            data;
  logic                  cmrom;
  logic [NUM_CMRAM-1:0]  cmram;
  // trace drain port and status
  logic                  trace_valid;
  logic                  trace_ready;
  logic [RW-1:0]         trace_data;
  logic [CW-1:0]         trace_count;
  logic                  locked;
  logic                  sync_err;
  logic [OVF_WIDTH-1:0]  ovf_cnt;
  // debug view of the phase tracker state (A1=0 .. X3=7)
  logic [2:0]            phase;

  modport master (
    output clk2, sync, data, cmrom, cmram, trace_ready,
    input  trace_valid, trace_data, trace_count, locked, sync_err, ovf_cnt, phase
  );

  modport slave (
    input  clk2, sync, data, cmrom, cmram, trace_ready,
    output trace_valid, trace_data, trace_count, locked, sync_err, ovf_cnt, phase
  );
endinterface

// File: rtl/mcs4_bus_tracer.sv
// Passive MCS-4 bus tracer: follows the 8-phase instruction cycle on clk2
// falling edges, assembles {addr, opcode, X2 data, CM flags} per cycle and
// queues the records in a circular FIFO drained via valid/ready.
// Optional feature macro: MCS4_TRACE_TSTAMP_EN (instruction-cycle timestamp
// prepended as record MSBs).
module mcs4_bus_tracer #(
  parameter int NUM_CMRAM = 4,
  parameter int DEPTH     = 16,
  parameter int OVF_WIDTH = 8,
  parameter int TS_WIDTH  = 16
) (
  input  logic sysclk,
  input  logic poc_n,
  mcs4_bus_tracer_if.slave bus
);
`ifdef MCS4_TRACE_TSTAMP_EN
  localparam int TS_EN = 1;
`else
  localparam int TS_EN = 0;
`endif
  localparam int RW = 25 + NUM_CMRAM + TS_EN * TS_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // phase tracker and capture registers
  logic                 clk2_q;
  logic [2:0]           phase_q, phase_d;
  logic                 locked_q, locked_d;
  logic                 sync_err_q, sync_err_d;
  logic [6:0]           cap_q, cap_d;       // one bit per phase A1..X2 seen since lock
  logic [11:0]          addr_q, addr_d;
  logic [7:0]           op_q, op_d;
  logic [3:0]           xd_q, xd_d;
  logic                 rom_q, rom_d;
  logic [NUM_CMRAM-1:0] ram_q, ram_d;

  logic                 strobe;
  logic                 x3_ok;
  logic                 push;
  logic [RW-1:0]        rec;

  // FIFO
  logic [RW-1:0]        mem [DEPTH];
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic [OVF_WIDTH-1:0] ovf_q;
  logic [CW-1:0]        count;
  logic                 pop;
  logic                 push_ok;

  assign strobe = clk2_q & ~bus.clk2;

  // tracker state register; reset discards any partial record
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      clk2_q     <= 1'b0;
      phase_q    <= 3'd0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
      cap_q      <= '0;
      addr_q     <= '0;
      op_q       <= '0;
      xd_q       <= '0;
      rom_q      <= 1'b0;
      ram_q      <= '0;
    end else begin
      clk2_q     <= bus.clk2;
      phase_q    <= phase_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
      cap_q      <= cap_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      xd_q       <= xd_d;
      rom_q      <= rom_d;
      ram_q      <= ram_d;
    end
  end

  // next phase, lock/sync-error decisions and field capture on each strobe
  always_comb begin
    phase_d    = phase_q;
    locked_d   = locked_q;
    sync_err_d = sync_err_q;
    cap_d      = cap_q;
    addr_d     = addr_q;
    op_d       = op_q;
    xd_d       = xd_q;
    rom_d      = rom_q;
    ram_d      = ram_q;
    if (strobe) begin
      if (bus.sync && !locked_q) begin
        // first sync marks X3; next strobe is A1
        phase_d  = 3'd7;
        locked_d = 1'b1;
        cap_d    = '0;
      end else if (bus.sync && phase_q != 3'd6) begin
        // early sync: realign to X3 and drop the partial record
        sync_err_d = 1'b1;
        phase_d    = 3'd7;
        cap_d      = '0;
      end else if (locked_q && phase_q == 3'd6 && !bus.sync) begin
        // sync missing at X3: lose lock
        sync_err_d = 1'b1;
        locked_d   = 1'b0;
        cap_d      = '0;
        phase_d    = phase_q + 3'd1;
      end else begin
        phase_d = phase_q + 3'd1;
        if (locked_q) begin
          case (phase_d)
            3'd0: begin addr_d[3:0]  = bus.data; cap_d[0] = 1'b1; end
            3'd1: begin addr_d[7:4]  = bus.data; cap_d[1] = 1'b1; end
            3'd2: begin addr_d[11:8] = bus.data; cap_d[2] = 1'b1; end
            3'd3: begin op_d[7:4]    = bus.data; cap_d[3] = 1'b1; end
            3'd4: begin op_d[3:0]    = bus.data; cap_d[4] = 1'b1; end
            3'd5: cap_d[5] = 1'b1;
            3'd6: begin
              xd_d     = bus.data;
              rom_d    = bus.cmrom;
              ram_d    = bus.cmram;
              cap_d[6] = 1'b1;
            end
            default: cap_d = '0;  // valid X3: record handed off, start afresh
          endcase
        end
      end
    end
  end

`ifdef MCS4_TRACE_TSTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;

  // instruction-cycle counter; held at zero while unlocked
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n)        ts_q <= '0;
    else if (!locked_q) ts_q <= '0;
    else if (x3_ok)    ts_q <= ts_q + 1'b1;
  end
`endif

  // record assembly and push request on a valid, fully captured X3
  always_comb begin
    x3_ok = strobe && locked_q && (phase_q == 3'd6) && bus.sync;
    push  = x3_ok && (&cap_q);
`ifdef MCS4_TRACE_TSTAMP_EN
    rec   = {ts_q, addr_q, op_q, xd_q, rom_q, ram_q};
`else
    rec   = {addr_q, op_q, xd_q, rom_q, ram_q};
`endif
  end

  assign count   = wr_ptr_q - rd_ptr_q;
  assign pop     = (count != '0) && bus.trace_ready;
  assign push_ok = push && ((count != FULL_CNT) || pop);

  // record storage; contents need no reset since count gates visibility
  always_ff @(posedge sysclk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= rec;
  end

  // FIFO pointers and saturating drop counter
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !push_ok && ovf_q != '1) ovf_q <= ovf_q + 1'b1;
    end
  end

  assign bus.trace_valid = (count != '0);
  assign bus.trace_data  = (count != '0) ? mem[rd_ptr_q[AW-1:0]] : '0;
  assign bus.trace_count = count;
  assign bus.locked      = locked_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.ovf_cnt     = ovf_q;
  assign bus.phase       = phase_q;
endmodule

// File: tb/tb_mcs4_bus_tracer.sv
// Bench for mcs4_bus_tracer: table of instruction cycles replayed on a modelled
// clk2 bus, scoreboard queue of expected records, hand sequences for overflow,
// sync errors and mid-cycle reset. Optional macro: MCS4_TRACE_TSTAMP_EN.
module tb_mcs4_bus_tracer;
  localparam int NUM_CMRAM = 4;
  localparam int DEPTH     = 4;
  localparam int OVF_WIDTH = 8;
  localparam int TS_WIDTH  = 16;
`ifdef MCS4_TRACE_TSTAMP_EN
  localparam int TS_EN = 1;
`else
  localparam int TS_EN = 0;
`endif
  localparam int BW = 25 + NUM_CMRAM;
  localparam int RW = BW + TS_EN * TS_WIDTH;

  typedef struct {
    logic [11:0]          addr;
    logic [7:0]           op;
    logic [3:0]           xd;
    logic                 rom;
    logic [NUM_CMRAM-1:0] ram;
    logic [BW-1:0]        exp;
  } vec_t;

  logic sysclk;
  logic poc_n;

  mcs4_bus_tracer_if #(.NUM_CMRAM(NUM_CMRAM), .DEPTH(DEPTH), .OVF_WIDTH(OVF_WIDTH),
                       .TS_WIDTH(TS_WIDTH)) bus ();

  mcs4_bus_tracer #(.NUM_CMRAM(NUM_CMRAM), .DEPTH(DEPTH), .OVF_WIDTH(OVF_WIDTH),
                    .TS_WIDTH(TS_WIDTH)) dut (
    .sysclk (sysclk),
    .poc_n  (poc_n),
    .bus    (bus)
  );

  // clock/reset block
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard and bench-side model state
  logic [RW-1:0]       exp_q[$];
  int                  n_cmp = 0;
  int                  n_err = 0;
  int                  mdl_cnt = 0;
  int                  ovf_exp = 0;
  bit                  tb_locked = 0;
  bit                  err_exp = 0;
  logic [TS_WIDTH-1:0] ts_exp = '0;
  vec_t                tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input logic [BW-1:0] b);
`ifdef MCS4_TRACE_TSTAMP_EN
    return {ts_exp, b};
`else
    return b;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mdl_cnt   = 0;
    ovf_exp   = 0;
    tb_locked = 0;
    err_exp   = 0;
    ts_exp    = '0;
  endtask

  // driver: one bus phase = 4 sysclks, clk2 high for 2 then low for 2
  task automatic do_phase(input logic [3:0] d, input logic s, input logic rom,
                          input logic [NUM_CMRAM-1:0] ram, input bit pop, input bit lat);
    bus.data  = d;
    bus.sync  = s;
    bus.cmrom = rom;
    bus.cmram = ram;
    bus.clk2  = 1'b1;
    repeat (2) @(negedge sysclk);
    bus.clk2 = 1'b0;
    if (pop) begin
      bus.trace_ready = 1'b1;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL pop_at_x3: got valid=%0b expected a queued record", bus.trace_valid);
      end else begin
        check("pop_at_x3", 64'(bus.trace_data), 64'(exp_q.pop_front()));
        mdl_cnt--;
      end
    end
    if (lat) check("valid_before_x3_edge", 64'(bus.trace_valid), 64'd0);
    @(negedge sysclk);
    bus.trace_ready = 1'b0;
    if (lat) check("valid_after_x3_edge", 64'(bus.trace_valid), 64'd1);
    @(negedge sysclk);
  endtask

  // driver: full A1..X3 instruction cycle, with scoreboard update at X3
  task automatic do_cycle(input vec_t v, input bit x3_sync, input bit pop, input bit lat);
    do_phase(v.addr[3:0],  1'b0, 1'b0, '0, 1'b0, 1'b0);
    do_phase(v.addr[7:4],  1'b0, 1'b0, '0, 1'b0, 1'b0);
    do_phase(v.addr[11:8], 1'b0, 1'b0, '0, 1'b0, 1'b0);
    do_phase(v.op[7:4],    1'b0, 1'b0, '0, 1'b0, 1'b0);
    do_phase(v.op[3:0],    1'b0, 1'b0, '0, 1'b0, 1'b0);
    do_phase(4'h0,         1'b0, 1'b0, '0, 1'b0, 1'b0);
    do_phase(v.xd,         1'b0, v.rom, v.ram, 1'b0, 1'b0);
    do_phase(4'h0,         x3_sync, 1'b0, '0, pop, lat);
    if (x3_sync) begin
      if (!tb_locked) begin
        tb_locked = 1;
        ts_exp    = '0;
      end else begin
        if (mdl_cnt < DEPTH) begin
          exp_q.push_back(mk(v.exp));
          mdl_cnt++;
        end else if (ovf_exp < 255) begin
          ovf_exp++;
        end
        ts_exp = ts_exp + 1'b1;
      end
    end else if (tb_locked) begin
      tb_locked = 0;
      err_exp   = 1;
      ts_exp    = '0;
    end
  endtask

  // consumer: drain FIFO comparing every record against the expected queue
  task automatic drain();
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (bus.trace_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL drain_extra: got %0h expected no record", bus.trace_data);
        end else begin
          check("drain_rec", 64'(bus.trace_data), 64'(exp_q.pop_front()));
          mdl_cnt--;
        end
      end else if (exp_q.size() == 0) begin
        break;
      end
      @(negedge sysclk);
    end
    bus.trace_ready = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_missing: got %0d records short expected 0", exp_q.size());
      exp_q.delete();
    end
    mdl_cnt = 0;
    check("drain_empty", 64'(bus.trace_count), 64'd0);
  endtask

  initial begin
    poc_n = 1'b0;
    bus.clk2 = 1'b0; bus.sync = 1'b0; bus.data = '0; bus.cmrom = 1'b0; bus.cmram = '0;
    bus.trace_ready = 1'b0;

    tbl[0] = '{12'h123, 8'hD5, 4'h5, 1'b1, 4'h0, {12'h123, 8'hD5, 4'h5, 1'b1, 4'h0}};
    tbl[1] = '{12'hFFF, 8'hFF, 4'hF, 1'b1, 4'hF, {12'hFFF, 8'hFF, 4'hF, 1'b1, 4'hF}};
    tbl[2] = '{12'h000, 8'h00, 4'h0, 1'b0, 4'h0, {12'h000, 8'h00, 4'h0, 1'b0, 4'h0}};
    tbl[3] = '{12'hA5C, 8'h3E, 4'h9, 1'b0, 4'hA, {12'hA5C, 8'h3E, 4'h9, 1'b0, 4'hA}};
    tbl[4] = '{12'h5A3, 8'hC1, 4'h6, 1'b1, 4'h5, {12'h5A3, 8'hC1, 4'h6, 1'b1, 4'h5}};
    tbl[5] = '{12'h0F0, 8'h81, 4'h2, 1'b0, 4'h1, {12'h0F0, 8'h81, 4'h2, 1'b0, 4'h1}};
    for (int i = 6; i < 8; i++) begin
      tbl[i].addr = 12'($urandom_range(0, 4095));
      tbl[i].op   = 8'($urandom_range(0, 255));
      tbl[i].xd   = 4'($urandom_range(0, 15));
      tbl[i].rom  = 1'($urandom_range(0, 1));
      tbl[i].ram  = NUM_CMRAM'($urandom_range(0, (1 << NUM_CMRAM) - 1));
      tbl[i].exp  = {tbl[i].addr, tbl[i].op, tbl[i].xd, tbl[i].rom, tbl[i].ram};
    end

    // reset held while the bus toggles, including sync
    @(negedge sysclk);
    for (int i = 0; i < 4; i++)
      do_phase(4'($urandom_range(0, 15)), 1'(i[0]), 1'b1, '1, 1'b0, 1'b0);
    check("rst_valid",    64'(bus.trace_valid), 64'd0);
    check("rst_count",    64'(bus.trace_count), 64'd0);
    check("rst_locked",   64'(bus.locked),      64'd0);
    check("rst_sync_err", 64'(bus.sync_err),    64'd0);
    check("rst_ovf",      64'(bus.ovf_cnt),     64'd0);
    check("rst_data",     64'(bus.trace_data),  64'd0);
    poc_n = 1'b1;
    model_reset();

    // lock on a lone sync, then one clean cycle with latency check
    do_phase(4'h0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    tb_locked = 1; ts_exp = '0;
    check("lock", 64'(bus.locked), 64'd1);
    check("lock_no_record", 64'(bus.trace_count), 64'd0);
    do_cycle(tbl[0], 1'b1, 1'b0, 1'b1);
    check("clean_count", 64'(bus.trace_count), 64'd1);
    check("clean_rec_const", 64'(bus.trace_data[BW-1:0]), 64'h247AAB0);
    drain();

    // table-driven single cycles
    for (int i = 1; i < 8; i++) begin
      do_cycle(tbl[i], 1'b1, 1'b0, 1'b0);
      check("tbl_count", 64'(bus.trace_count), 64'(mdl_cnt));
      drain();
    end
    check("tbl_sync_err", 64'(bus.sync_err), 64'd0);

    // overflow: six cycles into a 4-deep FIFO with no consumer
    for (int i = 0; i < 6; i++) do_cycle(tbl[i], 1'b1, 1'b0, 1'b0);
    check("ovf_cnt",   64'(bus.ovf_cnt),     64'd2);
    check("ovf_model", 64'(bus.ovf_cnt),     64'(ovf_exp));
    check("ovf_count", 64'(bus.trace_count), 64'd4);

    // full FIFO with a pop in the X3 strobe cycle: push accepted
    do_cycle(tbl[6], 1'b1, 1'b1, 1'b0);
    check("fullpop_count", 64'(bus.trace_count), 64'd4);
    check("fullpop_ovf",   64'(bus.ovf_cnt),     64'd2);
    drain();

    // early sync at M2 while locked
    do_phase(tbl[3].addr[3:0],  1'b0, 1'b0, '0, 1'b0, 1'b0);
    do_phase(tbl[3].addr[7:4],  1'b0, 1'b0, '0, 1'b0, 1'b0);
    do_phase(tbl[3].addr[11:8], 1'b0, 1'b0, '0, 1'b0, 1'b0);
    do_phase(tbl[3].op[7:4],    1'b0, 1'b0, '0, 1'b0, 1'b0);
    do_phase(tbl[3].op[3:0],    1'b1, 1'b0, '0, 1'b0, 1'b0);
    err_exp = 1;
    check("serr_flag",   64'(bus.sync_err),    64'd1);
    check("serr_locked", 64'(bus.locked),      64'd1);
    check("serr_count",  64'(bus.trace_count), 64'd0);
    do_cycle(tbl[4], 1'b1, 1'b0, 1'b0);
    check("serr_next_count", 64'(bus.trace_count), 64'd1);
    drain();

    // sync missing at X3: lock lost, no record, relock next X3
    do_cycle(tbl[5], 1'b0, 1'b0, 1'b0);
    check("nosync_locked", 64'(bus.locked),      64'd0);
    check("nosync_count",  64'(bus.trace_count), 64'd0);
    check("nosync_err",    64'(bus.sync_err),    64'(err_exp));
    do_cycle(tbl[5], 1'b1, 1'b0, 1'b0);
    check("relock", 64'(bus.locked), 64'd1);
    check("relock_count", 64'(bus.trace_count), 64'd0);
    do_cycle(tbl[7], 1'b1, 1'b0, 1'b0);
    drain();

    // reset pulsed in the middle of M1 with a record queued
    do_cycle(tbl[1], 1'b1, 1'b0, 1'b0);
    check("pre_rst_count", 64'(bus.trace_count), 64'd1);
    do_phase(tbl[2].addr[3:0],  1'b0, 1'b0, '0, 1'b0, 1'b0);
    do_phase(tbl[2].addr[7:4],  1'b0, 1'b0, '0, 1'b0, 1'b0);
    do_phase(tbl[2].addr[11:8], 1'b0, 1'b0, '0, 1'b0, 1'b0);
    bus.data = tbl[2].op[7:4];
    bus.clk2 = 1'b1;
    @(negedge sysclk);
    #2 poc_n = 1'b0;
    #1;
    check("mid_rst_count",  64'(bus.trace_count), 64'd0);
    check("mid_rst_valid",  64'(bus.trace_valid), 64'd0);
    check("mid_rst_locked", 64'(bus.locked),      64'd0);
    check("mid_rst_err",    64'(bus.sync_err),    64'd0);
    model_reset();
    @(negedge sysclk);
    poc_n = 1'b1;
    bus.clk2 = 1'b0;
    repeat (2) @(negedge sysclk);
    do_cycle(tbl[2], 1'b1, 1'b0, 1'b0);
    check("after_rst_lock",  64'(bus.locked),      64'd1);
    check("after_rst_count", 64'(bus.trace_count), 64'd0);
    do_cycle(tbl[3], 1'b1, 1'b0, 1'b0);
    check("after_rst_rec", 64'(bus.trace_count), 64'd1);
    drain();

`ifdef MCS4_TRACE_TSTAMP_EN
    // timestamps after a fresh lock count 0,1,2
    @(negedge sysclk);
    poc_n = 1'b0;
    model_reset();
    @(negedge sysclk);
    poc_n = 1'b1;
    do_phase(4'h0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    tb_locked = 1; ts_exp = '0;
    for (int i = 0; i < 3; i++) do_cycle(tbl[i], 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("ts_field", 64'(bus.trace_data[RW-1 -: TS_WIDTH]), 64'(k));
      check("ts_rec", 64'(bus.trace_data), 64'(exp_q.pop_front()));
      mdl_cnt--;
      bus.trace_ready = 1'b1;
      @(negedge sysclk);
      bus.trace_ready = 1'b0;
    end
    check("ts_empty", 64'(bus.trace_count), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
